// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: front-end sequencer between the decode stage and the datapath ALU.
//
// Accepts one R-type operation per request (valid/ready), decodes the MIPS funct
// field into the ALU control code, registers the operands onto the ALU inputs,
// waits out the ALU enable register plus its ALU_DELAY pipeline and returns the
// captured result/status (or an illegal-funct error) on a valid/ready response
// channel. Only one operation is in flight at a time.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   req_valid/req_ready            request handshake
//   req_funct/shamt/op_a/op_b      request payload (op_a -> ALU data[1], op_b -> data[0])
//   rsp_valid/rsp_ready            response handshake
//   rsp_result/rsp_status/rsp_err  response payload
//   alu_en_n/ctrl/shamt/dataIn     ALU input side (dataIn = {op_a, op_b})
//   alu_dataOut/alu_status         ALU output side
//   busy                           high whenever not idle
//
// Optional feature, macro ALU_ISSUE_PERF_EN: adds saturating counters
//   perf_ops (legal operations completed) and perf_err (illegal-funct responses),
//   both counted at the response handshake.

module alu_issue_ctrl #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned CTRL_WIDTH   = 5,
    parameter int unsigned STATUS_WIDTH = 4,
    parameter int unsigned SHAMT_WIDTH  = 5,
    parameter int unsigned ALU_DELAY    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [5:0]              req_funct,
    input  logic [SHAMT_WIDTH-1:0]  req_shamt,
    input  logic [DATA_WIDTH-1:0]   req_op_a,
    input  logic [DATA_WIDTH-1:0]   req_op_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_result,
    output logic [STATUS_WIDTH-1:0] rsp_status,
    output logic                    rsp_err,
    output logic                    alu_en_n,
    output logic [CTRL_WIDTH-1:0]   alu_ctrl,
    output logic [SHAMT_WIDTH-1:0]  alu_shamt,
    output logic [2*DATA_WIDTH-1:0] alu_dataIn,
    input  logic [DATA_WIDTH-1:0]   alu_dataOut,
    input  logic [STATUS_WIDTH-1:0] alu_status,
    output logic                    busy
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]             perf_ops,
    output logic [15:0]             perf_err
`endif
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_t;

    // Covers the ALU en_n register (+1) and its pipeline; counts down to 0 for capture.
    localparam logic [4:0] CntInit = 5'(ALU_DELAY + 1);

    state_t                  state_q, state_d;
    logic [4:0]              cnt_q, cnt_d;
    logic                    en_n_q, en_n_d;
    logic [CTRL_WIDTH-1:0]   ctrl_q, ctrl_d;
    logic [SHAMT_WIDTH-1:0]  shamt_q, shamt_d;
    logic [2*DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic [STATUS_WIDTH-1:0] status_q, status_d;
    logic                    err_q, err_d;

    logic [4:0]              dec_code;
    logic                    dec_legal;

    // funct -> ALU control code
    always_comb begin
        dec_code  = 5'h00;
        dec_legal = 1'b1;
        case (req_funct)
            6'h24:        dec_code = 5'h00;  // and
            6'h25:        dec_code = 5'h01;  // or
            6'h27:        dec_code = 5'h02;  // nor
            6'h26:        dec_code = 5'h03;  // xor
            6'h20, 6'h21: dec_code = 5'h04;  // add/addu
            6'h22, 6'h23: dec_code = 5'h05;  // sub/subu
            6'h18:        dec_code = 5'h06;  // mult
            6'h2A:        dec_code = 5'h07;  // slt
            6'h02:        dec_code = 5'h08;  // srl
            6'h00:        dec_code = 5'h09;  // sll
            6'h03:        dec_code = 5'h0A;  // sra
            6'h10:        dec_code = 5'h0B;  // mfhi
            6'h12:        dec_code = 5'h0C;  // mflo
            6'h11:        dec_code = 5'h0D;  // mthi
            6'h13:        dec_code = 5'h0E;  // mtlo
            6'h06:        dec_code = 5'h0F;  // srlv
            6'h04:        dec_code = 5'h10;  // sllv
            6'h07:        dec_code = 5'h11;  // srav
            default:      dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        en_n_d   = en_n_q;
        ctrl_d   = ctrl_q;
        shamt_d  = shamt_q;
        data_d   = data_q;
        result_d = result_q;
        status_d = status_q;
        err_d    = err_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (dec_legal) begin
                        ctrl_d  = CTRL_WIDTH'(dec_code);
                        shamt_d = req_shamt;
                        data_d  = {req_op_a, req_op_b};
                        en_n_d  = 1'b0;
                        cnt_d   = CntInit;
                        state_d = StIssue;
                    end else begin
                        // No ALU access for an illegal funct; answer directly.
                        err_d    = 1'b1;
                        result_d = '0;
                        status_d = '0;
                        state_d  = StResp;
                    end
                end
            end
            StIssue: begin
                if (cnt_q == 5'd0) begin
                    result_d = alu_dataOut;
                    status_d = alu_status;
                    err_d    = 1'b0;
                    en_n_d   = 1'b1;
                    state_d  = StResp;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            en_n_q   <= 1'b1;
            ctrl_q   <= '0;
            shamt_q  <= '0;
            data_q   <= '0;
            result_q <= '0;
            status_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            en_n_q   <= en_n_d;
            ctrl_q   <= ctrl_d;
            shamt_q  <= shamt_d;
            data_q   <= data_d;
            result_q <= result_d;
            status_q <= status_d;
            err_q    <= err_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign rsp_valid  = (state_q == StResp);
    assign busy       = (state_q != StIdle);
    assign rsp_result = result_q;
    assign rsp_status = status_q;
    assign rsp_err    = err_q;
    assign alu_en_n   = en_n_q;
    assign alu_ctrl   = ctrl_q;
    assign alu_shamt  = shamt_q;
    assign alu_dataIn = data_q;

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_ops_q;
    logic [15:0] perf_err_q;
    logic        rsp_hs;

    assign rsp_hs = (state_q == StResp) && rsp_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_ops_q <= '0;
            perf_err_q <= '0;
        end else if (rsp_hs) begin
            if (!err_q && (perf_ops_q != '1)) perf_ops_q <= perf_ops_q + 32'd1;
            if (err_q && (perf_err_q != '1))  perf_err_q <= perf_err_q + 16'd1;
        end
    end

    assign perf_ops = perf_ops_q;
    assign perf_err = perf_err_q;
`endif

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Front-end sequencer that drives the datapath ALU on its ctrl/dataIn/shamt/en_n side and collects its dataOut/status result.
- Accepts one R-type operation per request through a valid/ready handshake and decodes the MIPS funct field into the 5-bit ALU control code.
- Packs the operands, waits out the ALU's enable registration and delay pipeline, then returns result, status and error through a valid/ready response channel.
- Sits between the decode stage and the ALU.

Parameters:
DATA_WIDTH, 32, operand/result width
CTRL_WIDTH, 5, ALU control code width
STATUS_WIDTH, 4, ALU status width ([0] zero, [1] sign, [2] carry, [3] overflow)
SHAMT_WIDTH, 5, shift-amount width
ALU_DELAY, 0, DELAY parameter of the attached ALU (0..15)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_funct  in  6  MIPS funct field
req_shamt  in  SHAMT_WIDTH  immediate shift amount
req_op_a  in  DATA_WIDTH  operand A (ALU data[1])
req_op_b  in  DATA_WIDTH  operand B (ALU data[0])
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  DATA_WIDTH  captured ALU dataOut
rsp_status  out  STATUS_WIDTH  captured ALU status
rsp_err  out  1  illegal funct
alu_en_n  out  1  ALU enable, active low
alu_ctrl  out  CTRL_WIDTH  ALU control code
alu_shamt  out  SHAMT_WIDTH  ALU shamt
alu_dataIn  out  2*DATA_WIDTH  packed operands: {op_a, op_b}
alu_dataOut  in  DATA_WIDTH  ALU result
alu_status  in  STATUS_WIDTH  ALU status
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n=0 at a clock edge, from any state, including mid-operation):
  - State returns to IDLE.
  - req_ready=1, rsp_valid=0, rsp_result=0, rsp_status=0, rsp_err=0.
  - alu_en_n=1, alu_ctrl=0, alu_shamt=0, alu_dataIn=0, busy=0.
  - An in-flight operation is discarded with no response.
- Funct decode (funct -> ctrl):
  - 0x24->0x0, 0x25->0x1, 0x27->0x2, 0x26->0x3
  - 0x20/0x21->0x4, 0x22/0x23->0x5, 0x18->0x6, 0x2A->0x7
  - 0x02->0x8, 0x00->0x9, 0x03->0xA
  - 0x10->0xB, 0x12->0xC, 0x11->0xD, 0x13->0xE
  - 0x06->0xF, 0x04->0x10, 0x07->0x11
  - Any other funct is illegal.
- States: IDLE, ISSUE, RESP.
- IDLE: req_ready=1. On req_valid&req_ready with a legal funct:
  - Register alu_ctrl, alu_shamt, alu_dataIn={req_op_a,req_op_b}.
  - Set alu_en_n=0 and wait counter=ALU_DELAY+1.
  - Go to ISSUE.
- IDLE with an illegal funct:
  - No ALU access.
  - rsp_err=1, rsp_result=0, rsp_status=0; go to RESP.
- ISSUE:
  - req_ready=0; ALU inputs held stable.
  - Counter decrements each cycle.
  - On the cycle the counter reads 0: capture alu_dataOut/alu_status into rsp_result/rsp_status, set rsp_err=0, drive alu_en_n=1, go to RESP.
- Issue-to-capture latency is ALU_DELAY+2 cycles: one cycle for the ALU's en_n register, ALU_DELAY cycles for its pipeline, plus the input register.
- RESP:
  - rsp_valid=1; response outputs stable until rsp_valid&rsp_ready.
  - On handshake: rsp_valid=0, go to IDLE.
  - req_ready stays 0 while in RESP, so no back-to-back overlap.
  - Minimum spacing between accepted requests is ALU_DELAY+4 cycles.
- mult (0x18):
  - rsp_result = low word only; the ALU retains hi/lo internally.
  - mfhi/mflo issued later return those values.
- mthi/mtlo: rsp_result is whatever the ALU drives (0 from a conforming ALU); the response is still produced.
- Not-ready / late-ready:
  - req_valid with req_ready=0 is ignored; the requester holds it.
  - rsp_ready high before rsp_valid has no effect.
- Counter width is 5 bits; ALU_DELAY>15 is unsupported.

Optional Feature:
- Macro ALU_ISSUE_PERF_EN.
- When defined, add outputs:
  - perf_ops (32, count of legal operations completed at the RESP handshake).
  - perf_err (16, count of illegal-funct responses).
- Both counters saturate at all-ones and reset to 0 on rst_n=0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-ISSUE (ALU_DELAY=2) -> next cycle busy=0, req_ready=1, rsp_valid=0, alu_en_n=1; no response ever appears.
- add, ALU_DELAY=0: funct 0x20, A=0xFFFFFFFF, B=0x1 -> after 2 cycles in ISSUE, rsp_result=0x0, rsp_status[0]=1, rsp_status[2]=1, rsp_err=0.
- sra with shamt=4, A=x, B=0x80000000 -> alu_ctrl=0xA, rsp_result=0xF8000000. Then srlv 0x06 with A=0x100, B=4 -> alu_ctrl=0xF, rsp_result=0x10.
- mult, then mfhi: A=0x10000, B=0x10000 -> rsp_result=0x0; next request funct 0x10 -> rsp_result=0x1.
- Illegal funct 0x3F -> RESP next cycle, rsp_err=1, rsp_result=0, alu_en_n stays 1. Hold rsp_ready=0 for 5 cycles -> outputs stable, req_ready=0 throughout.
- With ALU_ISSUE_PERF_EN: 3 legal ops + 2 illegal ops -> perf_ops=3, perf_err=2. Without the macro the bench compiles without these ports.
